// File: rtl/decrypted_mem_writer.sv
// decrypted_mem_writer: writes one decrypted byte to RAM per start/finish handshake, reads it back after RD_LAT cycles, flags readback mismatch and non-lowercase/space plaintext
module decrypted_mem_writer #(
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 2,
  parameter bit CHECK_ASCII = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  input  logic [ADDR_W-1:0] FSM_Adr,
  input  logic [7:0]        FSM_Data,
  output logic [ADDR_W-1:0] Decrypt_Adr,
  output logic [7:0]        Decrypt_Data,
  output logic              Decrypt_Wren,
  input  logic [7:0]        DataIn_from_Decrypt,
  output logic              verify_err,
  output logic              char_invalid,
  output logic [ADDR_W:0]   wr_count
);
  localparam int CW = $clog2(RD_LAT + 1);
  typedef enum logic [2:0] {IDLE, WRITE, WAIT, CHECK, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic ascii_ok;
  assign ascii_ok = (Decrypt_Data >= 8'h61 && Decrypt_Data <= 8'h7A) || Decrypt_Data == 8'h20;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      finish <= 1'b0;
      Decrypt_Wren <= 1'b0;
      verify_err <= 1'b0;
      char_invalid <= 1'b0;
      Decrypt_Adr <= '0;
      Decrypt_Data <= '0;
      wr_count <= '0;
    end else begin
      finish <= 1'b0;
      Decrypt_Wren <= 1'b0;
      case (state)
        IDLE: if (start) begin
          Decrypt_Adr <= FSM_Adr;
          Decrypt_Data <= FSM_Data;
          Decrypt_Wren <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(RD_LAT - 1) ? CHECK : WAIT;
        end
        CHECK: begin
          verify_err <= DataIn_from_Decrypt != Decrypt_Data;
          char_invalid <= CHECK_ASCII && !ascii_ok;
          finish <= 1'b1;
          wr_count <= wr_count + {{ADDR_W{1'b0}}, ~&wr_count};
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_decrypted_mem_writer.sv
// tb_decrypted_mem_writer: randomized self-checking bench with RAM model and transaction-level reference
module tb_decrypted_mem_writer;
  localparam int AW = 5;
  localparam int RDL = 2;
  localparam int LAT = 3 + RDL;
  localparam int CMAX = (1 << (AW + 1)) - 1;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] FSM_Adr = '0;
  logic [7:0] FSM_Data = '0;
  logic finish, Decrypt_Wren, verify_err, char_invalid;
  logic [AW-1:0] Decrypt_Adr;
  logic [7:0] Decrypt_Data, q;
  logic [AW:0] wr_count;
  logic finish_n, wren_n, verr_n, ci_n;
  logic [AW-1:0] adr_n;
  logic [7:0] data_n;
  logic [AW:0] cnt_n;
  logic [7:0] ram [32];
  logic [7:0] exp_mem [32];
  logic [7:0] pipe [RDL];
  bit corrupt = 1'b0;
  int n_chk = 0, n_fail = 0, cyc = 0, model_cnt = 0, fin_cyc = 0;
  decrypted_mem_writer #(.ADDR_W(AW), .RD_LAT(RDL), .CHECK_ASCII(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .FSM_Adr(FSM_Adr), .FSM_Data(FSM_Data),
    .Decrypt_Adr(Decrypt_Adr), .Decrypt_Data(Decrypt_Data), .Decrypt_Wren(Decrypt_Wren),
    .DataIn_from_Decrypt(q), .verify_err(verify_err), .char_invalid(char_invalid), .wr_count(wr_count));
  decrypted_mem_writer #(.ADDR_W(AW), .RD_LAT(RDL), .CHECK_ASCII(1'b0)) dut_noascii (
    .clk(clk), .reset(reset), .start(start), .finish(finish_n), .FSM_Adr(FSM_Adr), .FSM_Data(FSM_Data),
    .Decrypt_Adr(adr_n), .Decrypt_Data(data_n), .Decrypt_Wren(wren_n),
    .DataIn_from_Decrypt(q), .verify_err(verr_n), .char_invalid(ci_n), .wr_count(cnt_n));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (Decrypt_Wren) ram[Decrypt_Adr] <= Decrypt_Data;
    pipe[0] <= ram[Decrypt_Adr];
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign q = corrupt ? 8'h00 : pipe[RDL-1];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit bad_char(input logic [7:0] d);
    return !((d >= 8'h61 && d <= 8'h7A) || d == 8'h20);
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
  endtask
  task automatic txn(input logic [AW-1:0] a, input logic [7:0] d, input bit keep, input bit bad_rd);
    int wren_cnt, wren_k, fin_k;
    logic [AW-1:0] wa;
    logic [7:0] wd;
    wren_cnt = 0;
    wren_k = 0;
    fin_k = 0;
    wa = '0;
    wd = '0;
    @(negedge clk);
    FSM_Adr = a;
    FSM_Data = d;
    start = 1'b1;
    corrupt = bad_rd;
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
    FSM_Adr = AW'($urandom);
    FSM_Data = 8'($urandom);
    for (int k = 1; k <= LAT + 3 && fin_k == 0; k++) begin
      @(negedge clk);
      if (Decrypt_Wren) begin
        wren_cnt++;
        wren_k = k;
        wa = Decrypt_Adr;
        wd = Decrypt_Data;
      end
      if (finish) begin
        fin_k = k;
        fin_cyc = cyc;
      end
    end
    exp_mem[a] = d;
    model_cnt = model_cnt < CMAX ? model_cnt + 1 : CMAX;
    check("wren_pulses", wren_cnt, 1);
    check("wren_cycle", wren_k, 1);
    check("wr_adr", wa, a);
    check("wr_data", wd, d);
    check("finish_cycle", fin_k, LAT);
    check("verify_err", verify_err, bad_rd);
    check("char_invalid", char_invalid, bad_char(d));
    check("char_invalid_off", ci_n, 0);
    check("wr_count", wr_count, model_cnt);
    check("adr_held", Decrypt_Adr, a);
    check("data_held", Decrypt_Data, d);
  endtask
  initial begin
    int prev, wcnt, fcnt;
    for (int i = 0; i < 32; i++) begin
      ram[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_finish", finish, 0);
    check("rst_wren", Decrypt_Wren, 0);
    check("rst_verr", verify_err, 0);
    check("rst_cinv", char_invalid, 0);
    check("rst_adr", Decrypt_Adr, 0);
    check("rst_data", Decrypt_Data, 0);
    check("rst_count", wr_count, 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_wren", Decrypt_Wren, 0);
      check("idle_finish", finish, 0);
    end
    txn(5'h03, 8'h68, 1'b0, 1'b0);
    txn(5'h04, 8'h41, 1'b0, 1'b0);
    txn(5'h05, 8'h20, 1'b0, 1'b0);
    txn(5'h06, 8'h7A, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("verr_held", verify_err, 1);
    end
    corrupt = 1'b0;
    txn(5'h1F, 8'h7B, 1'b0, 1'b0);
    @(negedge clk);
    FSM_Adr = 5'h0A;
    FSM_Data = 8'h71;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_mem[5'h0A] = 8'h71;
    model_cnt = 0;
    wcnt = 0;
    fcnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (Decrypt_Wren) wcnt++;
      if (finish) fcnt++;
      @(negedge clk);
    end
    check("abort_finish", fcnt, 0);
    check("abort_wren", wcnt, 0);
    check("abort_count", wr_count, 0);
    txn(5'h0B, 8'h62, 1'b0, 1'b0);
    do_reset();
    prev = 0;
    for (int i = 0; i < 32; i++) begin
      txn(AW'(i), 8'h61 + 8'(i % 26), i < 31, 1'b0);
      if (i > 0) check("b2b_spacing", fin_cyc - prev, LAT + 1);
      prev = fin_cyc;
    end
    check("b2b_count", wr_count, 32);
    @(negedge clk);
    for (int i = 0; i < 32; i++) check("ram_contents", ram[i], exp_mem[i]);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = $urandom_range(0, 1) ? 8'h61 + 8'($urandom_range(0, 25)) : 8'($urandom);
      txn(AW'($urandom), d, 1'b0, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("sat_count", wr_count, CMAX);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
